// File: rtl/mux2_rr_sequencer_if.sv
// Handshake bundle between the two upstream sources, the 2:1 mux sequencer and its downstream sink.
// The slave modport is the sequencer's view; master is the view of the surrounding logic.
interface mux2_rr_sequencer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in0_data;
    logic              in0_valid;
    logic              in0_ready;
    logic [DATA_W-1:0] in1_data;
    logic              in1_valid;
    logic              in1_ready;
    logic [1:0]        select_line;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        beat_cnt;

    modport slave (
        input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
        output in0_ready, in1_ready, select_line, out_data, out_valid, beat_cnt
    );

    modport master (
        output in0_data, in0_valid, in1_data, in1_valid, out_ready,
        input  in0_ready, in1_ready, select_line, out_data, out_valid, beat_cnt
    );
endinterface

// File: rtl/mux2_rr_sequencer.sv
// Round-robin burst arbiter steering a 2:1 datapath mux, with a registered valid/ready output stage.
// select_line only changes on grant entry, so it is stable for every beat accepted under a grant.
module mux2_rr_sequencer #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux2_rr_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_LEN);

    state_t            state_r;
    logic              ptr_r;
    logic [1:0]        sel_r;
    logic [3:0]        cnt_r;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;

    logic              gnt1_s;
    logic              in_grant_s;
    logic              cur_valid_s;
    logic              oth_valid_s;
    logic [DATA_W-1:0] cur_data_s;
    logic              slot_s;
    logic              accept_s;
    logic [3:0]        cnt_inc_s;
    logic              release_s;

    // Decode the granted source and the accept/release conditions for this cycle.
    always_comb begin
        gnt1_s      = (state_r == GRANT1);
        in_grant_s  = (state_r != IDLE);
        cur_valid_s = gnt1_s ? bus.in1_valid : bus.in0_valid;
        oth_valid_s = gnt1_s ? bus.in0_valid : bus.in1_valid;
        cur_data_s  = gnt1_s ? bus.in1_data  : bus.in0_data;
        // The output register can take a beat when empty or being drained this cycle.
        slot_s      = !valid_r || bus.out_ready;
        accept_s    = in_grant_s && cur_valid_s && slot_s;
        cnt_inc_s   = cnt_r + 4'd1;
        release_s   = in_grant_s && (!cur_valid_s || (accept_s && (cnt_inc_s == BURST_LIM)));
    end

    assign bus.in0_ready   = (state_r == GRANT0) && slot_s;
    assign bus.in1_ready   = (state_r == GRANT1) && slot_s;
    assign bus.select_line = sel_r;
    assign bus.out_data    = data_r;
    assign bus.out_valid   = valid_r;
    assign bus.beat_cnt    = cnt_r;

    // Grant FSM, round-robin pointer, burst counter and output beat register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= 1'b0;
            sel_r   <= 2'b00;
            cnt_r   <= 4'd0;
            data_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                data_r  <= cur_data_s;
                valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end

            case (state_r)
                IDLE: begin
                    if (bus.in0_valid && (!bus.in1_valid || !ptr_r)) begin
                        state_r <= GRANT0;
                        sel_r   <= 2'b00;
                        cnt_r   <= 4'd0;
                    end else if (bus.in1_valid) begin
                        state_r <= GRANT1;
                        sel_r   <= 2'b01;
                        cnt_r   <= 4'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT0, GRANT1: begin
                    if (release_s) begin
                        // Pointer always moves to the other source on release.
                        ptr_r <= !gnt1_s;
                        if (oth_valid_s) begin
                            state_r <= gnt1_s ? GRANT0 : GRANT1;
                            sel_r   <= gnt1_s ? 2'b00 : 2'b01;
                            cnt_r   <= 4'd0;
                        end else if (cur_valid_s) begin
                            cnt_r   <= 4'd0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (accept_s) begin
                        cnt_r <= cnt_inc_s;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sel_r   <= 2'b00;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux2_rr_sequencer.sv
// Scoreboard bench for mux2_rr_sequencer: source queues feed beats, expected output order is queued up front.
module tb_mux2_rr_sequencer;

    logic clk;
    logic rst_n;

    mux2_rr_sequencer_if #(.DATA_W(8)) bus ();

    mux2_rr_sequencer #(.DATA_W(8), .BURST_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] src0_q[$];
    logic [7:0] src1_q[$];
    logic [7:0] exp_q[$];
    logic       en0;
    logic       en1;
    logic       ordy;
    int         acc0_n = 0;
    int         acc1_n = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_inputs();
        bus.in0_valid = en0 && (src0_q.size() > 0);
        if (bus.in0_valid) bus.in0_data = src0_q[0];
        else               bus.in0_data = 8'h00;
        bus.in1_valid = en1 && (src1_q.size() > 0);
        if (bus.in1_valid) bus.in1_data = src1_q[0];
        else               bus.in1_data = 8'h00;
        bus.out_ready = ordy;
    endtask

    // One clock: drive at negedge, sample handshakes 1 time unit before the rising edge.
    task automatic cycle();
        logic [7:0] e;
        logic [7:0] d;
        drive_inputs();
        #4;
        check_val("ready_excl", {31'd0, bus.in0_ready & bus.in1_ready}, 32'd0);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("out_data", {24'd0, bus.out_data}, {24'd0, e});
            end
        end
        if (bus.in0_valid && bus.in0_ready) begin
            check_val("sel_src0", {30'd0, bus.select_line}, 32'd0);
            d = src0_q.pop_front();
            acc0_n++;
        end
        if (bus.in1_valid && bus.in1_ready) begin
            check_val("sel_src1", {30'd0, bus.select_line}, 32'd1);
            d = src1_q.pop_front();
            acc1_n++;
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag, output int n);
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        check_val({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int k;
        int base;

        // Reset with both sources requesting.
        rst_n = 1'b0;
        en0   = 1'b1;
        en1   = 1'b1;
        ordy  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            src0_q.push_back(8'(i * 16 + 15));
            src1_q.push_back(8'(240 + i));
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i * 16 + 15));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(240 + i));
        for (int i = 4; i < 8; i++) exp_q.push_back(8'(i * 16 + 15));
        for (int i = 4; i < 8; i++) exp_q.push_back(8'(240 + i));
        drive_inputs();
        @(negedge clk);
        check_val("rst_sel",    {30'd0, bus.select_line}, 32'd0);
        check_val("rst_ovalid", {31'd0, bus.out_valid},   32'd0);
        check_val("rst_odata",  {24'd0, bus.out_data},    32'd0);
        check_val("rst_cnt",    {28'd0, bus.beat_cnt},    32'd0);
        check_val("rst_rdy0",   {31'd0, bus.in0_ready},   32'd0);
        check_val("rst_rdy1",   {31'd0, bus.in1_ready},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_rdy0", {31'd0, bus.in0_ready},   32'd1);
        check_val("post_rst_rdy1", {31'd0, bus.in1_ready},   32'd0);
        check_val("post_rst_sel",  {30'd0, bus.select_line}, 32'd0);

        // Contention: 4 beats per grant alternating, no idle cycles.
        drain("cont", n);
        check_val("cont_cycles", 32'(n), 32'd17);
        cycle();
        cycle();

        // Single source on in1 with a re-grant after 4 beats.
        src1_q = '{8'h55, 8'hAA, 8'hFF, 8'h01, 8'h02, 8'h03};
        exp_q  = '{8'h55, 8'hAA, 8'hFF, 8'h01, 8'h02, 8'h03};
        drain("single", n);
        check_val("single_cycles", 32'(n), 32'd8);
        cycle();
        cycle();

        // Backpressure mid-burst on source 0.
        base   = acc0_n;
        src0_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        exp_q  = '{8'h10, 8'h11, 8'h12, 8'h13};
        k = 0;
        while (acc0_n < base + 2 && k < 20) begin
            cycle();
            k++;
        end
        check_val("bp_acc2", 32'(acc0_n - base), 32'd2);
        check_val("bp_cnt_pre", {28'd0, bus.beat_cnt}, 32'd2);
        ordy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_val("bp_odata",  {24'd0, bus.out_data},  32'h11);
            check_val("bp_ovalid", {31'd0, bus.out_valid}, 32'd1);
            check_val("bp_rdy0",   {31'd0, bus.in0_ready}, 32'd0);
            check_val("bp_cnt",    {28'd0, bus.beat_cnt},  32'd2);
        end
        ordy = 1'b1;
        k = 0;
        while (acc0_n < base + 3 && k < 20) begin
            cycle();
            k++;
        end
        check_val("bp_cnt_post", {28'd0, bus.beat_cnt}, 32'd3);
        drain("bp", n);
        check_val("bp_total", 32'(acc0_n - base), 32'd4);
        cycle();
        cycle();

        // Early release: in0 drops after 2 beats while in1 waits.
        en1    = 1'b0;
        base   = acc0_n;
        src0_q = '{8'h20, 8'h21};
        src1_q = '{8'h30, 8'h31, 8'h32};
        exp_q  = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h32};
        k = 0;
        while (acc0_n < base + 1 && k < 20) begin
            cycle();
            k++;
        end
        en1 = 1'b1;
        while (acc0_n < base + 2 && k < 40) begin
            cycle();
            k++;
        end
        cycle();
        check_val("early_sel",  {30'd0, bus.select_line}, 32'd1);
        check_val("early_cnt",  {28'd0, bus.beat_cnt},    32'd0);
        check_val("early_rdy1", {31'd0, bus.in1_ready},   32'd1);
        check_val("early_rdy0", {31'd0, bus.in0_ready},   32'd0);
        drain("early", n);
        cycle();
        cycle();

        // Asynchronous reset at beat 3 of an in1 burst.
        en0  = 1'b0;
        base = acc1_n;
        for (int i = 0; i < 8; i++) begin
            src1_q.push_back(8'(64 + i));
            exp_q.push_back(8'(64 + i));
        end
        k = 0;
        while (acc1_n < base + 3 && k < 20) begin
            cycle();
            k++;
        end
        check_val("mrst_sel_pre", {30'd0, bus.select_line}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mrst_ovalid", {31'd0, bus.out_valid},   32'd0);
        check_val("mrst_sel",    {30'd0, bus.select_line}, 32'd0);
        check_val("mrst_cnt",    {28'd0, bus.beat_cnt},    32'd0);
        check_val("mrst_rdy1",   {31'd0, bus.in1_ready},   32'd0);
        exp_q.delete();
        src1_q.delete();
        drive_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check_val("mrst_idle_sel",    {30'd0, bus.select_line}, 32'd0);
        check_val("mrst_idle_ovalid", {31'd0, bus.out_valid},   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
